// File: rtl/pipeline_register.sv
// pipeline_register: a chain of P_STAGES valid/ready data registers.
// Each stage accepts a word when it is empty or its downstream neighbour is
// moving, so bubbles collapse. Supports a synchronous flush and an occupancy
// count.
// Optional feature: define PIPELINE_REGISTER_SKID_EN to add a one-entry skid
// buffer at the input. This makes O_READY come from a flop instead of the
// combinational ready chain.
module pipeline_register #(
  parameter int P_WIDTH  = 16,
  parameter int P_STAGES = 2
) (
  input  logic                          I_CLK,
  input  logic                          I_RESET,
  input  logic                          I_FLUSH,
  input  logic                          I_VALID,
  output logic                          O_READY,
  input  logic [P_WIDTH-1:0]            I_DATA,
  output logic                          O_VALID,
  input  logic                          I_READY,
  output logic [P_WIDTH-1:0]            O_DATA,
  output logic [$clog2(P_STAGES+2)-1:0] O_COUNT
);

  localparam int CW = $clog2(P_STAGES+2);

  logic [P_STAGES-1:0] vld_q;
  logic [P_STAGES-1:0] vld_d;
  logic [P_WIDTH-1:0]  data_q [P_STAGES];

  // rdy[k]: stage k can take a word this cycle (the end of the chain is I_READY)
  logic [P_STAGES-1:0] rdy;

  // What each stage would load: stage 0 from the input side, others from k-1
  logic [P_STAGES-1:0] stg_src_vld;
  logic [P_WIDTH-1:0]  stg_src_data [P_STAGES];

  // Input-side word presented to stage 0 (skid contents or I_DATA)
  logic               src_vld;
  logic [P_WIDTH-1:0] src_data;

  logic          xfer_in;
  logic          xfer_out;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Ready ripples back from the output: a stage is ready if empty or if the next one is ready
  always_comb begin : ready_chain
    logic r;
    r   = I_READY;
    rdy = '0;
    for (int k = P_STAGES - 1; k >= 0; k--) begin
      r      = ~vld_q[k] | r;
      rdy[k] = r;
    end
  end

`ifdef PIPELINE_REGISTER_SKID_EN
  logic               skid_vld_q;
  logic               skid_vld_d;
  logic [P_WIDTH-1:0] skid_data_q;
  logic [P_WIDTH-1:0] skid_data_d;

  // Ready depends only on skid occupancy, so no combinational path from I_READY
  assign O_READY  = ~skid_vld_q & ~I_RESET;
  assign xfer_in  = I_VALID & O_READY;
  // A held skid word has priority; otherwise the input bypasses straight into stage 0
  assign src_vld  = skid_vld_q | xfer_in;
  assign src_data = skid_vld_q ? skid_data_q : I_DATA;

  // Park an accepted word when stage 0 is blocked; release it when stage 0 frees up
  always_comb begin
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    if (I_FLUSH) begin
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      if (rdy[0]) skid_vld_d = 1'b0;
    end else if (xfer_in && !rdy[0]) begin
      skid_vld_d  = 1'b1;
      skid_data_d = I_DATA;
    end
  end

  // Skid buffer state
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
    end else begin
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
    end
  end
`else
  // Without a skid the input sees the full combinational ready chain
  assign O_READY  = rdy[0] & ~I_RESET;
  assign xfer_in  = I_VALID & O_READY;
  assign src_vld  = xfer_in;
  assign src_data = I_DATA;
`endif

  // Per-stage source selection and next valid bit
  for (genvar gi = 0; gi < P_STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign stg_src_vld[gi]  = src_vld;
      assign stg_src_data[gi] = src_data;
    end else begin : g_body
      assign stg_src_vld[gi]  = vld_q[gi-1];
      assign stg_src_data[gi] = data_q[gi-1];
    end
    // A ready stage takes whatever its source offers; a full ready stage has
    // already handed its word on, so overwriting the bit is safe
    assign vld_d[gi] = I_FLUSH ? 1'b0 : (rdy[gi] ? stg_src_vld[gi] : vld_q[gi]);
  end

  // Stage valid bits
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Stage data: loaded only on a real move, empty stages keep stale data
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      for (int k = 0; k < P_STAGES; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < P_STAGES; k++) begin
        if (rdy[k] && stg_src_vld[k]) data_q[k] <= stg_src_data[k];
      end
    end
  end

  assign xfer_out = vld_q[P_STAGES-1] & I_READY;

  // Occupancy follows accepted minus emitted words; flush empties everything
  always_comb begin
    count_d = count_q;
    if (I_FLUSH) begin
      count_d = '0;
    end else if (xfer_in && !xfer_out) begin
      count_d = count_q + CW'(1);
    end else if (xfer_out && !xfer_in) begin
      count_d = count_q - CW'(1);
    end
  end

  // Occupancy counter
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign O_VALID = vld_q[P_STAGES-1];
  assign O_DATA  = data_q[P_STAGES-1];
  assign O_COUNT = count_q;

endmodule

// File: tb/tb_pipeline_register.sv
// Testbench for pipeline_register (P_WIDTH=16, P_STAGES=3).
// The reference model is a FIFO of words, each tagged with its accept edge.
// The front word is visible P-1 edges after its accept. Ready and occupancy
// follow directly from the queue length.
module tb_pipeline_register;
  localparam int W = 16;
  localparam int P = 3;
`ifdef PIPELINE_REGISTER_SKID_EN
  localparam int CAP  = P + 1;
  localparam bit SKID = 1'b1;
`else
  localparam int CAP  = P;
  localparam bit SKID = 1'b0;
`endif
  localparam int CW = $clog2(P + 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          vld_i;
  logic          rdy_o;
  logic [W-1:0]  data_i;
  logic          vld_o;
  logic          rdy_i;
  logic [W-1:0]  data_o;
  logic [CW-1:0] count_o;

  pipeline_register #(.P_WIDTH(W), .P_STAGES(P)) dut (
    .I_CLK   (clk),
    .I_RESET (rst),
    .I_FLUSH (flush),
    .I_VALID (vld_i),
    .O_READY (rdy_o),
    .I_DATA  (data_i),
    .O_VALID (vld_o),
    .I_READY (rdy_i),
    .O_DATA  (data_o),
    .O_COUNT (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           entry;
  } word_t;

  word_t q[$];
  int    cyc    = 0;
  int    errors = 0;
  int    checks = 0;

  function automatic bit exp_valid();
    if (q.size() == 0) return 1'b0;
    return cyc >= q[0].entry + P - 1;
  endfunction

  function automatic bit exp_ready();
    if (rst) return 1'b0;
    if (SKID) return q.size() < CAP;
    return !(q.size() == P && !rdy_i);
  endfunction

  // Advance one rising edge, update the model from the inputs, return at the falling edge
  task automatic tick();
    bit xin;
    bit xout;
    xin  = vld_i && exp_ready();
    xout = exp_valid() && rdy_i;
    @(posedge clk);
    cyc++;
    if (rst || flush) begin
      q.delete();
    end else begin
      if (xout) void'(q.pop_front());
      if (xin) q.push_back(word_t'{data: data_i, entry: cyc});
    end
    @(negedge clk);
  endtask

  task automatic drain();
    vld_i = 1'b0; rdy_i = 1'b1; flush = 1'b0;
    for (int i = 0; i < CAP + 2; i++) tick();
  endtask

  task automatic push(input logic [W-1:0] d);
    vld_i = 1'b1; data_i = d;
    tick();
    vld_i = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    #1;
    checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b need 0", vld_o); end
    checks++; if (rdy_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b need 0", rdy_o); end
    checks++; if (count_o !== '0) begin errors++; $display("FAIL reset_count: got %0d need 0", count_o); end
    checks++; if (data_o !== '0) begin errors++; $display("FAIL reset_data: got %h need 0000", data_o); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (rdy_o !== 1'b1) begin errors++; $display("FAIL release_ready: got %b need 1", rdy_o); end
    $display("test_reset done at cycle %0d", cyc);
  endtask

  task automatic test_stream();
    int acc  = -1;
    int seen = -1;
    drain();
    rdy_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      vld_i  = (i < 8);
      data_i = W'(i + 1);
      #1;
      if (vld_o && data_o == 16'h0001 && seen < 0) seen = cyc;
      checks++; if (vld_o !== exp_valid()) begin errors++; $display("FAIL stream_valid cyc=%0d: got %b need %b", cyc, vld_o, exp_valid()); end
      if (exp_valid()) begin
        checks++; if (data_o !== q[0].data) begin errors++; $display("FAIL stream_data cyc=%0d: got %h need %h", cyc, data_o, q[0].data); end
      end
      if (i >= 3 && i <= 8) begin
        checks++; if (count_o !== CW'(3)) begin errors++; $display("FAIL stream_count cyc=%0d: got %0d need 3", cyc, count_o); end
      end
      tick();
      if (i == 0) acc = cyc;
    end
    vld_i = 1'b0;
    checks++; if (seen - acc != P - 1) begin errors++; $display("FAIL stream_latency: got %0d edges need %0d", seen - acc, P - 1); end
    $display("test_stream: first word accepted edge %0d seen after edge %0d", acc, seen);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] got[$];
    int idx = 0;
    bit acc;
    drain();
    rdy_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vld_i  = (idx < 4);
      data_i = W'(16'hA0 + idx);
      #1;
      checks++; if (rdy_o !== exp_ready()) begin errors++; $display("FAIL bp_ready cyc=%0d: got %b need %b", cyc, rdy_o, exp_ready()); end
      acc = vld_i && exp_ready();
      tick();
      if (acc) idx++;
    end
    vld_i = 1'b0;
    #1;
    checks++; if (count_o !== CW'(CAP)) begin errors++; $display("FAIL bp_count: got %0d need %0d", count_o, CAP); end
    checks++; if (rdy_o !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b need 0", rdy_o); end
    rdy_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (vld_o) got.push_back(data_o);
      tick();
    end
    checks++; if (got.size() != CAP) begin errors++; $display("FAIL bp_drain_len: got %0d need %0d", got.size(), CAP); end
    for (int k = 0; k < got.size() && k < CAP; k++) begin
      checks++; if (got[k] !== W'(16'hA0 + k)) begin errors++; $display("FAIL bp_order[%0d]: got %h need %h", k, got[k], W'(16'hA0 + k)); end
    end
    #1;
    checks++; if (count_o !== '0) begin errors++; $display("FAIL bp_empty_count: got %0d need 0", count_o); end
    $display("test_backpressure: %0d words drained", got.size());
  endtask

  task automatic test_bubble();
    drain();
    rdy_i = 1'b0;
    push(16'h0011);
    tick(); tick();
    push(16'h0022);
    tick(); tick(); tick();
    #1;
    checks++; if (count_o !== CW'(2)) begin errors++; $display("FAIL bubble_count: got %0d need 2", count_o); end
    checks++; if (vld_o !== 1'b1 || data_o !== 16'h0011) begin errors++; $display("FAIL bubble_head: got %b/%h need 1/0011", vld_o, data_o); end
    rdy_i = 1'b1;
    tick();
    #1;
    checks++; if (vld_o !== 1'b1 || data_o !== 16'h0022) begin errors++; $display("FAIL bubble_second: got %b/%h need 1/0022", vld_o, data_o); end
    tick();
    #1;
    checks++; if (vld_o !== 1'b0 || count_o !== '0) begin errors++; $display("FAIL bubble_empty: got %b/%0d need 0/0", vld_o, count_o); end
    $display("test_bubble done at cycle %0d", cyc);
  endtask

  task automatic test_full_pass();
    int n;
    int seen = -1;
    drain();
    rdy_i = 1'b0;
    push(16'h0031); push(16'h0032); push(16'h0033);
    vld_i = 1'b1; data_i = 16'h0055; rdy_i = 1'b1;
    #1;
    checks++; if (rdy_o !== 1'b1) begin errors++; $display("FAIL full_ready: got %b need 1", rdy_o); end
    tick();
    n = cyc;
    vld_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i == 0) begin
        checks++; if (count_o !== CW'(3)) begin errors++; $display("FAIL full_count: got %0d need 3", count_o); end
      end
      if (vld_o && data_o == 16'h0055 && seen < 0) seen = cyc;
      checks++; if (vld_o !== exp_valid()) begin errors++; $display("FAIL full_valid cyc=%0d: got %b need %b", cyc, vld_o, exp_valid()); end
      tick();
    end
    checks++; if (seen - n != P - 1) begin errors++; $display("FAIL full_latency: got %0d edges need %0d", seen - n, P - 1); end
    $display("test_full_pass: 0x55 accepted edge %0d seen after edge %0d", n, seen);
  endtask

  task automatic test_flush();
    drain();
    rdy_i = 1'b0;
    push(16'h0061); push(16'h0062); push(16'h0063);
    flush = 1'b1; vld_i = 1'b1; data_i = 16'h0077; rdy_i = 1'b1;
    #1;
    checks++; if (vld_o !== 1'b1) begin errors++; $display("FAIL flush_unmasked: got %b need 1", vld_o); end
    tick();
    flush = 1'b0; vld_i = 1'b0;
    #1;
    checks++; if (vld_o !== 1'b0 || count_o !== '0) begin errors++; $display("FAIL flush_clear: got %b/%0d need 0/0", vld_o, count_o); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (vld_o !== 1'b0 || data_o === 16'h0077) begin errors++; $display("FAIL flush_leak cyc=%0d: got %b/%h", cyc, vld_o, data_o); end
      tick();
      #1;
    end
    $display("test_flush done at cycle %0d", cyc);
  endtask

  task automatic test_reset_mid();
    int acc;
    int seen = -1;
    drain();
    rdy_i = 1'b1;
    push(16'h0041); push(16'h0042); push(16'h0043);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b need 0", vld_o); end
    checks++; if (rdy_o !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b need 0", rdy_o); end
    checks++; if (count_o !== '0) begin errors++; $display("FAIL midrst_count: got %0d need 0", count_o); end
    q.delete();
    tick();
    rst = 1'b0;
    push(16'h0099);
    acc = cyc;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (vld_o && data_o == 16'h0099 && seen < 0) seen = cyc;
      checks++; if (vld_o !== exp_valid()) begin errors++; $display("FAIL midrst_out cyc=%0d: got %b need %b", cyc, vld_o, exp_valid()); end
      tick();
    end
    checks++; if (seen - acc != P - 1) begin errors++; $display("FAIL midrst_latency: got %0d edges need %0d", seen - acc, P - 1); end
    $display("test_reset_mid: 0x99 accepted edge %0d seen after edge %0d", acc, seen);
  endtask

  task automatic test_random();
    drain();
    for (int i = 0; i < 400; i++) begin
      vld_i  = ($urandom_range(0, 99) < 60);
      rdy_i  = ($urandom_range(0, 99) < 65);
      data_i = W'($urandom);
      flush  = ($urandom_range(0, 49) == 0);
      #1;
      checks++; if (vld_o !== exp_valid()) begin errors++; $display("FAIL rand_valid cyc=%0d: got %b need %b", cyc, vld_o, exp_valid()); end
      if (exp_valid()) begin
        checks++; if (data_o !== q[0].data) begin errors++; $display("FAIL rand_data cyc=%0d: got %h need %h", cyc, data_o, q[0].data); end
      end
      checks++; if (count_o !== CW'(q.size())) begin errors++; $display("FAIL rand_count cyc=%0d: got %0d need %0d", cyc, count_o, q.size()); end
      checks++; if (rdy_o !== exp_ready()) begin errors++; $display("FAIL rand_ready cyc=%0d: got %b need %b", cyc, rdy_o, exp_ready()); end
      tick();
    end
    flush = 1'b0;
    $display("test_random done at cycle %0d", cyc);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; vld_i = 1'b0; rdy_i = 1'b0; data_i = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_full_pass();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
